// File: rtl/pagerank_sched_pp.sv
// PageRank iteration scheduler: load rank vector, iterate num_iters times over the PE array via a ping-pong buffer, unload.
// Dispatch/unload hold data stable until accepted; one SWAP cycle per iteration. PAGERANK_CONV_EN adds the early-exit check.
module pagerank_sched_pp #(
   parameter int NBITS  = 32,
   parameter int NNODES = 8,
   parameter int NPE    = 2,
   parameter int ADDRW  = $clog2(NNODES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   input  logic [7:0]             num_iters,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [NBITS-1:0]       in_data,
   output logic [NPE-1:0]         pe_req_val,
   input  logic [NPE-1:0]         pe_req_rdy,
   output logic [NPE*ADDRW-1:0]   pe_req_idx,
   output logic [NPE*NBITS-1:0]   pe_req_rank,
   input  logic [NPE-1:0]         pe_resp_val,
   output logic [NPE-1:0]         pe_resp_rdy,
   input  logic [NPE*ADDRW-1:0]   pe_resp_idx,
   input  logic [NPE*NBITS-1:0]   pe_resp_rank,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [NBITS-1:0]       out_data,
   output logic                   busy,
   output logic [7:0]             iter_count
`ifdef PAGERANK_CONV_EN
   ,
   input  logic [NBITS-1:0]       conv_thresh,
   output logic                   converged
`endif
);

   localparam int CHW  = (NPE > 1) ? $clog2(NPE) : 1;
   localparam int CNTW = ADDRW + 1;
   localparam logic [ADDRW-1:0] LAST = ADDRW'(NNODES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SWAP, S_OUTPUT} state_t;

   state_t             state, state_nxt;
   logic [NBITS-1:0]   buf0 [NNODES];
   logic [NBITS-1:0]   buf1 [NNODES];
   logic [NBITS-1:0]   cur  [NNODES];
   logic               sel;
   logic [ADDRW-1:0]   ld_ptr, out_ptr;
   logic [CNTW-1:0]    disp_ptr, resp_cnt, acc_cnt;
   logic [CHW-1:0]     disp_ch;
   logic [7:0]         iters_q;
   logic               disp_active, req_fire, conv_hit;

   // sel==0: buf0 holds the current ranks, buf1 collects the next ones
   always_comb begin
      for (int i = 0; i < NNODES; i++) cur[i] = sel ? buf1[i] : buf0[i];
   end

   assign disp_active = (state == S_RUN) && (disp_ptr < CNTW'(NNODES));

   always_comb begin
      state_nxt   = state;
      in_rdy      = 1'b0;
      out_val     = 1'b0;
      out_data    = '0;
      busy        = (state != S_IDLE);
      pe_req_val  = '0;
      pe_req_idx  = '0;
      pe_req_rank = '0;
      pe_resp_rdy = '0;
      req_fire    = 1'b0;
      acc_cnt     = resp_cnt;
      case (state)
         S_IDLE: if (go) state_nxt = S_LOAD;
         S_LOAD: begin
            in_rdy = 1'b1;
            if (in_val && ld_ptr == LAST) state_nxt = (iters_q == 8'd0) ? S_OUTPUT : S_RUN;
         end
         S_RUN: begin
            pe_resp_rdy = '1;
            for (int k = 0; k < NPE; k++) begin
               if (disp_active && disp_ch == CHW'(k)) begin
                  pe_req_val[k]                    = 1'b1;
                  pe_req_idx[k*ADDRW +: ADDRW]     = disp_ptr[ADDRW-1:0];
                  pe_req_rank[k*NBITS +: NBITS]    = cur[disp_ptr[ADDRW-1:0]];
                  req_fire                         = pe_req_rdy[k];
               end
               acc_cnt = acc_cnt + CNTW'(pe_resp_val[k]);
            end
            if (acc_cnt >= CNTW'(NNODES)) state_nxt = S_SWAP;
         end
         S_SWAP: state_nxt = ((iter_count + 8'd1) == iters_q || conv_hit) ? S_OUTPUT : S_RUN;
         S_OUTPUT: begin
            out_val  = 1'b1;
            out_data = cur[out_ptr];
            if (out_rdy && out_ptr == LAST) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sel        <= 1'b0;
         ld_ptr     <= '0;
         out_ptr    <= '0;
         disp_ptr   <= '0;
         disp_ch    <= '0;
         resp_cnt   <= '0;
         iters_q    <= '0;
         iter_count <= '0;
         for (int i = 0; i < NNODES; i++) begin
            buf0[i] <= '0;
            buf1[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: if (go) begin
               iters_q    <= num_iters;
               iter_count <= '0;
               ld_ptr     <= '0;
               out_ptr    <= '0;
               disp_ptr   <= '0;
               disp_ch    <= '0;
               resp_cnt   <= '0;
            end
            S_LOAD: if (in_val) begin
               if (sel) buf1[ld_ptr] <= in_data;
               else     buf0[ld_ptr] <= in_data;
               ld_ptr <= (ld_ptr == LAST) ? '0 : ld_ptr + 1'b1;
            end
            S_RUN: begin
               if (req_fire) begin
                  disp_ptr <= disp_ptr + 1'b1;
                  disp_ch  <= (disp_ch == CHW'(NPE - 1)) ? '0 : disp_ch + 1'b1;
               end
               // ascending loop: the highest channel's write lands last on a duplicate idx
               for (int k = 0; k < NPE; k++) begin
                  if (pe_resp_val[k]) begin
                     if (sel) buf0[pe_resp_idx[k*ADDRW +: ADDRW]] <= pe_resp_rank[k*NBITS +: NBITS];
                     else     buf1[pe_resp_idx[k*ADDRW +: ADDRW]] <= pe_resp_rank[k*NBITS +: NBITS];
                  end
               end
               resp_cnt <= acc_cnt;
            end
            S_SWAP: begin
               sel        <= ~sel;
               iter_count <= iter_count + 8'd1;
               disp_ptr   <= '0;
               disp_ch    <= '0;
               resp_cnt   <= '0;
            end
            S_OUTPUT: if (out_rdy) out_ptr <= (out_ptr == LAST) ? '0 : out_ptr + 1'b1;
            default: ;
         endcase
      end
   end

`ifdef PAGERANK_CONV_EN
   logic [NBITS-1:0] thresh_q, delta_sum, delta_nxt, old_r, new_r, diff;
   logic [NBITS:0]   sum_w;

   always_comb begin
      delta_nxt = delta_sum;
      old_r     = '0;
      new_r     = '0;
      diff      = '0;
      sum_w     = '0;
      for (int k = 0; k < NPE; k++) begin
         if (state == S_RUN && pe_resp_val[k]) begin
            new_r     = pe_resp_rank[k*NBITS +: NBITS];
            old_r     = cur[pe_resp_idx[k*ADDRW +: ADDRW]];
            diff      = (new_r >= old_r) ? new_r - old_r : old_r - new_r;
            sum_w     = {1'b0, delta_nxt} + {1'b0, diff};
            delta_nxt = sum_w[NBITS] ? '1 : sum_w[NBITS-1:0];
         end
      end
   end

   assign conv_hit = (delta_sum <= thresh_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         thresh_q  <= '0;
         delta_sum <= '0;
         converged <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (go) begin
               thresh_q  <= conv_thresh;
               delta_sum <= '0;
               converged <= 1'b0;
            end
            S_RUN:  delta_sum <= delta_nxt;
            S_SWAP: begin
               delta_sum <= '0;
               if (conv_hit) converged <= 1'b1;
            end
            default: ;
         endcase
      end
   end
`else
   assign conv_hit = 1'b0;
`endif

endmodule
